mem_refill_arbiter: RTL
=======================

# mem_refill_arbiter

Shares the single RAM read port between the instruction-cache refill path and the data-cache refill path. Each cache controller raises a block-refill request with its block address. The arbiter grants one requester at a time with round-robin fairness and issues one block-aligned burst request to RAM. It then counts the returning words, steers each word's valid strobe to the granted requester only, and signals completion. It sits between the two cache controllers and the RAM model/interface.

## Interface
Parameters:
- `ADDR_W`, 32: address width, equal to `pc_size`.
- `WORD_W`, 32: RAM word width, equal to `memory_word`.
- `BLOCK_BITS`, 512: cache block size in bits, equal to `icache_blocksize`.
- Derived:
  - `BURST_LEN` = BLOCK_BITS/WORD_W, default 16.
  - `OFF` = log2(BLOCK_BITS/8), default 6.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `i_req`  in  1  instruction-cache refill request; held high until `i_done`.
- `i_addr`  in  ADDR_W  instruction refill address; only bits above OFF are used.
- `d_req`  in  1  data-cache refill request; held high until `d_done`.
- `d_addr`  in  ADDR_W  data refill address.
- `mem_rdata`  in  WORD_W  word returned by RAM.
- `mem_rvalid`  in  1  `mem_rdata` is valid this cycle.
- `mem_req`  out  1  one-cycle burst start pulse to RAM.
- `mem_addr`  out  ADDR_W  block-aligned burst address; valid while `mem_req` is high.
- `word_out`  out  WORD_W  `mem_rdata` broadcast to both requesters.
- `i_word_ready`  out  1  word valid for the instruction cache.
- `d_word_ready`  out  1  word valid for the data cache.
- `i_done`  out  1  last word of the instruction burst.
- `d_done`  out  1  last word of the data burst.
- `busy`  out  1  arbiter is not in IDLE.

## Operation
- FSM states:
  - IDLE → ISSUE when `i_req | d_req`.
  - ISSUE → BURST unconditionally.
  - BURST → IDLE on the last counted word.
- Arbitration happens in IDLE only:
  - If only one request is high, that requester is granted.
  - If both are high, the requester not in `last_grant` is granted.
  - `grant` and `last_grant` are registered on the IDLE→ISSUE edge.
  - `last_grant` resets to DATA, so the instruction side wins the first tie.
- ISSUE:
  - `mem_req`=1.
  - `mem_addr` = {granted addr[ADDR_W-1:OFF], OFF'b0}, with the address sampled at grant time.
  - `word_cnt` cleared to 0.
- BURST:
  - Each `mem_rvalid` increments `word_cnt` (width log2(BURST_LEN)+1).
  - `x_word_ready` = `mem_rvalid` & (state==BURST) & (grant==x).
  - `x_done` = `x_word_ready` & (`word_cnt`==BURST_LEN-1).
- `word_out` = `mem_rdata` at all times (combinational).
- `mem_rvalid` outside BURST is ignored: no counting, no strobes.
- A requester dropping `req` mid-burst does not abort the burst. All BURST_LEN words are still consumed and strobed.
- A request asserted during BURST by either side waits. It is evaluated in the IDLE cycle that follows.
- `busy` = (state != IDLE).
- Reset (any time, including mid-burst):
  - state=IDLE, `word_cnt`=0, `grant`=INSTR, `last_grant`=DATA.
  - All outputs 0 except `word_out`, which follows `mem_rdata`.
  - A partially received burst is abandoned; the RAM side is expected to be reset by the same `nrst`.

## Timing
- Request seen high in IDLE at cycle t: `mem_req` high in cycle t+1 (ISSUE), BURST from t+2.
- Word strobes are combinational from `mem_rvalid` with zero added latency. Earliest first word is cycle t+2.
- Back-to-back `mem_rvalid` is supported at one word per cycle. Gaps of any length are allowed.
- `x_done` coincides with the final `x_word_ready`. State is IDLE at the next edge.
- A new grant cannot occur earlier than 1 cycle after `x_done`, giving a minimum 1-cycle IDLE bubble.
- Minimum refill turnaround is BURST_LEN+2 cycles per block.
- `mem_req` is high for exactly one cycle per grant and never while in BURST.

## Test plan
1. Reset, then `i_req`=1 with `i_addr`=0x0000_1234 and no `d_req`:
   - cycle+1: `mem_req`=1, `mem_addr`=0x0000_1200.
   - 16 consecutive `mem_rvalid` produce 16 `i_word_ready` pulses, `i_done` on the 16th, and `d_word_ready` never asserts.
2. `i_req` and `d_req` raised in the same cycle after reset, both held high:
   - Instruction is granted first. After `i_done` and one IDLE cycle, data is granted with `mem_addr` = aligned `d_addr`.
   - With both still requesting, a third grant goes to instruction (round-robin alternation).
3. `mem_rvalid` with gaps (1,0,0,1,…) during BURST: `word_cnt` advances only on valid cycles, and `done` fires on exactly the 16th valid word.
4. `mem_rvalid` pulsed while in IDLE and ISSUE: no `word_ready`, no `done`, and the later burst still requires 16 words.
5. `nrst` dropped after the 7th word of a data burst:
   - Outputs go to 0 asynchronously. After release, `busy`=0.
   - A fresh `d_req` restarts with a new `mem_req` and a full 16-word count.
6. `d_req` deasserted mid-burst: the burst still completes, all 16 `d_word_ready` pulses and `d_done` still occur, and a waiting `i_req` is granted next.

Source files
------------

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one RAM read port between the I-cache and
// D-cache refill paths. Round-robin grant, one block-aligned burst request
// per grant, word strobes steered to the granted side, done on the last word.
module mem_refill_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int BLOCK_BITS = 512
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] word_out,
    output logic              i_word_ready,
    output logic              d_word_ready,
    output logic              i_done,
    output logic              d_done,
    output logic              busy
);

    localparam int BURST_LEN = BLOCK_BITS / WORD_W;
    localparam int OFF       = $clog2(BLOCK_BITS / 8);
    localparam int CNT_W     = $clog2(BURST_LEN) + 1;

    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BURST_LEN - 1);
    // Clears the byte offset within a block; keeps every address bit in use.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFF) - 64'd1);

    // Requester encoding for grant / last_grant.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

    state_t            state;
    logic              grant;
    logic              last_grant;
    logic [CNT_W-1:0]  word_cnt;
    logic              pick_d;
    logic [ADDR_W-1:0] pick_addr;
    logic              in_burst;
    logic              last_word;

    // Round-robin pick: data wins alone, or on a tie when instruction went last.
    always_comb begin
        pick_d    = d_req & (~i_req | (last_grant == GNT_I));
        pick_addr = pick_d ? d_addr : i_addr;
    end

    // Arbitration FSM: grant in IDLE, one-cycle request pulse, then count words.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            grant      <= GNT_I;
            last_grant <= GNT_D;
            word_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            mem_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        grant      <= pick_d;
                        last_grant <= pick_d;
                        mem_req    <= 1'b1;
                        mem_addr   <= pick_addr & ALIGN_MASK;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    word_cnt <= '0;
                    state    <= BURST;
                end
                BURST: begin
                    // A dropped request does not abort; every word is consumed.
                    if (mem_rvalid) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                        if (word_cnt == LAST_CNT) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are combinational from mem_rvalid so words reach the cache with no added latency.
    always_comb begin
        in_burst     = (state == BURST);
        last_word    = (word_cnt == LAST_CNT);
        word_out     = mem_rdata;
        i_word_ready = mem_rvalid & in_burst & (grant == GNT_I);
        d_word_ready = mem_rvalid & in_burst & (grant == GNT_D);
        i_done       = i_word_ready & last_word;
        d_done       = d_word_ready & last_word;
        busy         = (state != IDLE);
    end

endmodule
